shift_add_multiplier: RTL and testbench
=======================================

// Module: shift_add_multiplier
// PURPOSE
//  Parametrised sequential shift-add multiplier: integrated FSM, iteration counter and datapath.
//  Computes WIDTH x WIDTH -> 2*WIDTH products, signed or unsigned per operation.
//  Optional early exit when the remaining multiplier bits are zero. Synchronous abort.
//  Sits beside the ALU as the multi-cycle MULT unit; the core stalls on busy and captures on done.
// PARAMETERS
//  WIDTH       8  operand width in bits (>=2); product is 2*WIDTH bits
//  EARLY_EXIT  1  1 = finish as soon as the shifted multiplier is 0; 0 = always WIDTH iterations
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        reset, asynchronous, active-low
//  start        in   1        request; accepted only on an edge where idle=1
//  signed_mode  in   1        sampled with start: 1 = two's-complement operands, 0 = unsigned
//  a            in   WIDTH    multiplicand, sampled on the accept edge
//  b            in   WIDTH    multiplier, sampled on the accept edge
//  abort        in   1        synchronous cancel; effective in ADD/SHIFT only
//  idle         out  1        1 in IDLE
//  busy         out  1        1 in ADD or SHIFT
//  done         out  1        1 for exactly one cycle, in DONE
//  product      out  2*WIDTH  registered result; updated only on entry to DONE, held otherwise
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE, idle=1, busy=0, done=0, product=0, all internal regs 0.
//  Datapath: acc[2W], mcand[2W], mplier[W], cnt[clog2(W)], neg flag.
//  FSM states and transitions:
//   IDLE : start=1 -> ADD. On the accept edge: acc=0, cnt=0.
//          Unsigned: mcand={0,a}, mplier=b, neg=0.
//          Signed: operands replaced by magnitudes, neg=a[W-1]^b[W-1].
//          Magnitude of -2^(W-1) is 2^(W-1), held unsigned in W bits.
//          start=0 -> stay IDLE.
//   ADD  : on the edge, acc += mcand if mplier[0]=1, else acc unchanged (mod 2^2W, no carry out). -> SHIFT.
//   SHIFT: on the edge, mcand <<= 1, mplier >>= 1, cnt += 1.
//          last = (cnt==W-1) | (EARLY_EXIT & (mplier>>1)==0).
//          last=1 -> DONE; product <= neg ? -acc : acc (2*W-bit two's complement).
//          last=0 -> ADD.
//   DONE : done=1. Unconditionally -> IDLE. start is ignored in DONE.
//   Illegal state encoding -> IDLE next edge.
//  abort=1 in ADD or SHIFT: -> IDLE next edge. No DONE, product unchanged. abort has priority over last.
//  abort in IDLE or DONE: no effect.
//  Latency (accept edge = edge 0): done is high between edges 2n and 2n+1.
//   n = iterations: W if EARLY_EXIT=0, else max(1, index of highest set bit of |b| + 1).
//  Throughput: with start held high, the next accept is the edge after DONE->IDLE,
//   i.e. one idle cycle between operations.
//  a, b and signed_mode are don't-care outside the accept edge; changing them mid-op has no effect.
//  Signed result is exact for all operand pairs, including (-2^(W-1))^2 = 2^(2W-2).
//  Async reset mid-operation: immediate IDLE; the operation is discarded; product cleared to 0.
// TESTING (WIDTH=8 unless noted)
//  1. unsigned a=13, b=11, EARLY_EXIT=0 -> product=0x008F, done high edges 16..17, busy edges 0..16.
//     Same with EARLY_EXIT=1 -> done high edges 8..9.
//  2. signed a=-3 (0xFD), b=5 -> 0xFFF1. signed a=0x80, b=0x80 -> 0x4000.
//     Signed a=0x7F, b=0x80 -> 0xC080.
//  3. unsigned a=255, b=255 -> 0xFE01.
//     Same operands signed -> 0x0001. Both EARLY_EXIT values give the same product.
//  4. b=0, EARLY_EXIT=1 -> product=0, done high edges 2..3. a=0, b=1 -> product=0, done edges 2..3.
//  5. After test 1, start 0x0F*0x0F, abort=1 at edge 5 -> idle=1 after edge 6.
//     done never pulses; product stays 0x008F.
//     abort in DONE ignored: done still pulses once.
//  6. rst low at edge 7 mid-op -> idle=1, product=0 immediately.
//     start held high for 3 ops of 2*3 -> three done pulses, each followed by one idle cycle; product=0x0006.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH), signed or unsigned per operation,
// with optional early exit and synchronous abort.
module shift_add_multiplier #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               abort,
  output logic               idle,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADD   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic             accept_c;
  logic             last_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;

  // Magnitudes are held unsigned in WIDTH bits, so -2^(W-1) maps to 2^(W-1) exactly
  always_comb begin
    accept_c = (state == S_IDLE) && start;
    a_mag_c  = (signed_mode && a[WIDTH-1]) ? WIDTH'(~a + 1'b1) : a;
    b_mag_c  = (signed_mode && b[WIDTH-1]) ? WIDTH'(~b + 1'b1) : b;
    last_c   = (cnt == CW'(WIDTH - 1)) ||
               (EARLY_EXIT && (mplier[WIDTH-1:1] == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next state; abort outranks completion in ADD/SHIFT
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = start ? S_ADD : S_IDLE;
      S_ADD:   state_nxt = abort ? S_IDLE : S_SHIFT;
      S_SHIFT: begin
        if (abort)       state_nxt = S_IDLE;
        else if (last_c) state_nxt = S_DONE;
        else             state_nxt = S_ADD;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status flags registered from the next state so they align with the state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      idle <= (state_nxt == S_IDLE);
      busy <= (state_nxt == S_ADD) || (state_nxt == S_SHIFT);
      done <= (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (accept_c) begin
      acc     <= '0;
      cnt     <= '0;
      mcand   <= PW'(a_mag_c);
      mplier  <= b_mag_c;
      neg     <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (!abort) begin
      if (state == S_ADD && mplier[0]) begin
        acc <= acc + mcand;
      end
      if (state == S_SHIFT) begin
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (last_c) product <= neg ? PW'(~acc + 1'b1) : acc;
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: one instance per EARLY_EXIT setting,
// product, latency, abort, reset and back-to-back throughput checks.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic        signed_mode;
  logic [7:0]  a, b;
  logic        abort;
  logic        idle0, busy0, done0, idle1, busy1, done1;
  logic [15:0] product0, product1;

  bit          sel;
  logic        idle_s, busy_s, done_s;
  logic [15:0] product_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .signed_mode(signed_mode),
    .a(a), .b(b), .abort(abort),
    .idle(idle0), .busy(busy0), .done(done0), .product(product0));

  shift_add_multiplier #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(signed_mode),
    .a(a), .b(b), .abort(abort),
    .idle(idle1), .busy(busy1), .done(done1), .product(product1));

  assign idle_s    = sel ? idle1 : idle0;
  assign busy_s    = sel ? busy1 : busy0;
  assign done_s    = sel ? done1 : done0;
  assign product_s = sel ? product1 : product0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is positioned #1 after an edge with the selected DUT idle
  task automatic do_op(input bit s, input bit sm, input logic [7:0] av, input logic [7:0] bv,
                       input int exp_p, input int exp_n, input string tag);
    int got;
    int bcnt;
    sel = s; signed_mode = sm; a = av; b = bv;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
    got = -1;
    bcnt = busy_s ? 1 : 0;
    for (int k = 1; k <= 60 && got < 0; k++) begin
      @(posedge clk); #1;
      if (done_s) got = k;
      else if (busy_s) bcnt++;
    end
    chk({tag, "_done_edge"}, got, 2 * exp_n);
    chk({tag, "_busy_cycles"}, bcnt, 2 * exp_n);
    chk({tag, "_product"}, int'(product_s), exp_p);
    @(posedge clk); #1;
    chk({tag, "_done_fall"}, int'(done_s), 0);
    chk({tag, "_idle_after"}, int'(idle_s), 1);
  endtask

  initial begin
    int dcnt;
    int got;
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
    signed_mode = 1'b0; a = '0; b = '0; sel = 1'b0;
    #12;
    chk("rst_idle0", int'(idle0), 1);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_prod0", int'(product0), 0);
    chk("rst_idle1", int'(idle1), 1);
    chk("rst_prod1", int'(product1), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    do_op(1'b0, 1'b0, 8'd13, 8'd11, 16'h008F, 8, "u13x11_ee0");
    do_op(1'b1, 1'b0, 8'd13, 8'd11, 16'h008F, 4, "u13x11_ee1");
    do_op(1'b1, 1'b1, 8'hFD, 8'd5,  16'hFFF1, 3, "s_m3x5");
    do_op(1'b1, 1'b1, 8'h80, 8'h80, 16'h4000, 8, "s_80x80");
    do_op(1'b0, 1'b1, 8'h7F, 8'h80, 16'hC080, 8, "s_7Fx80");
    do_op(1'b0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 8, "u_ffxff_ee0");
    do_op(1'b1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 8, "u_ffxff_ee1");
    do_op(1'b0, 1'b1, 8'hFF, 8'hFF, 16'h0001, 8, "s_ffxff_ee0");
    do_op(1'b1, 1'b1, 8'hFF, 8'hFF, 16'h0001, 1, "s_ffxff_ee1");
    do_op(1'b1, 1'b0, 8'd77, 8'd0,  16'h0000, 1, "b0_ee1");
    do_op(1'b1, 1'b0, 8'd0,  8'd1,  16'h0000, 1, "a0b1_ee1");
    do_op(1'b0, 1'b0, 8'd13, 8'd11, 16'h008F, 8, "u13x11_again");

    // Abort mid-operation on dut0
    sel = 1'b0; signed_mode = 1'b0; a = 8'h0F; b = 8'h0F; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_busy_before", int'(busy0), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", int'(idle0), 1);
    chk("abort_busy", int'(busy0), 0);
    dcnt = 0;
    repeat (20) begin @(posedge clk); #1; if (done0) dcnt++; end
    chk("abort_no_done", dcnt, 0);
    chk("abort_prod_held", int'(product0), 16'h008F);

    // Abort while in DONE has no effect
    sel = 1'b1; a = 8'd2; b = 8'd3; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    got = -1;
    for (int k = 1; k <= 40 && got < 0; k++) begin
      @(posedge clk); #1;
      if (done1) got = k;
    end
    chk("abort_in_done_edge", got, 4);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    dcnt = 0;
    repeat (10) begin @(posedge clk); #1; if (done1) dcnt++; end
    chk("abort_in_done_single", dcnt, 0);
    chk("abort_in_done_prod", int'(product1), 16'h0006);

    // Async reset mid-operation
    sel = 1'b0; a = 8'd13; b = 8'd11; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("mid_rst_idle", int'(idle0), 1);
    chk("mid_rst_busy", int'(busy0), 0);
    chk("mid_rst_prod", int'(product0), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // start held high: three back-to-back 2*3 operations on dut1
    sel = 1'b1; signed_mode = 1'b0; a = 8'd2; b = 8'd3; start1 = 1'b1;
    dcnt = 0;
    got = 0;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      if (k == 17) start1 = 1'b0;
      if (got == 1) chk("tput_idle_gap", int'(idle1), 1);
      got = done1 ? 1 : 0;
      if (done1) dcnt++;
    end
    chk("tput_pulses", dcnt, 3);
    chk("tput_prod", int'(product1), 16'h0006);
    repeat (3) begin @(posedge clk); #1; end
    chk("tput_idle_end", int'(idle1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
